// File: rtl/run_sequencer.sv
// Sequences one program run of the single-cycle core: holds it in reset while idle,
// releases and counts RUN cycles, drains after halt, then reports done via four-phase req/done.
module run_sequencer #(
  parameter int unsigned INIT_CYC  = 2,
  parameter int unsigned DRAIN_CYC = 1,
  parameter int unsigned CW        = 16,
  parameter int unsigned MAX_CYC   = 50000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          halt,
  output logic          core_reset,
  output logic          core_en,
  output logic          done,
  output logic          timeout,
  output logic [CW-1:0] cycle_cnt
);

  typedef enum logic [2:0] {StIdle, StInit, StRun, StDrain, StDone} state_e;

  localparam logic [3:0]    InitLast  = 4'(INIT_CYC - 1);
  localparam logic [3:0]    DrainLast = 4'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);
  localparam logic [CW-1:0] WdogLast  = CW'(MAX_CYC - 1);
  localparam logic [CW-1:0] CntMax    = '1;

  state_e        state_q, state_d;
  logic [3:0]    phase_q, phase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      phase_q   <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    unique case (state_q)
      StIdle: begin
        // DONE only exits on req=0, so any req seen here is a fresh request
        if (req) begin
          state_d   = StInit;
          phase_d   = '0;
          cnt_d     = '0;
          timeout_d = 1'b0;
        end
      end
      StInit: begin
        if (phase_q == InitLast) begin
          state_d = StRun;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 4'd1;
        end
      end
      StRun: begin
        if (cnt_q != CntMax) cnt_d = cnt_q + CW'(1);
        // halt takes priority over the watchdog on the same edge
        if (halt) begin
          state_d = (DRAIN_CYC == 0) ? StDone : StDrain;
          phase_d = '0;
        end else if (cnt_q == WdogLast) begin
          state_d   = StDone;
          timeout_d = 1'b1;
        end
      end
      StDrain: begin
        if (phase_q == DrainLast) begin
          state_d = StDone;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 4'd1;
        end
      end
      StDone: begin
        if (!req) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    core_reset = 1'b0;
    core_en    = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      StIdle:  core_reset = 1'b1;
      StInit:  core_reset = 1'b1;
      StRun:   core_en    = 1'b1;
      StDrain: ;
      StDone:  done       = 1'b1;
      default: core_reset = 1'b1;
    endcase
  end

  assign timeout   = timeout_q;
  assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Bench for run_sequencer: two parameterisations driven with directed and random runs,
// checked cycle by cycle against a per-run timeline model.
module tb_run_sequencer;

  logic        clk;
  logic        reset;
  logic        req[2];
  logic        halt[2];
  logic        cr[2];
  logic        en[2];
  logic        dn[2];
  logic        to[2];
  logic [15:0] cnt[2];

  int checks = 0;
  int errors = 0;

  run_sequencer #(
    .INIT_CYC (2),
    .DRAIN_CYC(1),
    .CW       (16),
    .MAX_CYC  (8)
  ) dut0 (
    .clk       (clk),
    .reset     (reset),
    .req       (req[0]),
    .halt      (halt[0]),
    .core_reset(cr[0]),
    .core_en   (en[0]),
    .done      (dn[0]),
    .timeout   (to[0]),
    .cycle_cnt (cnt[0])
  );

  run_sequencer #(
    .INIT_CYC (3),
    .DRAIN_CYC(0),
    .CW       (16),
    .MAX_CYC  (12)
  ) dut1 (
    .clk       (clk),
    .reset     (reset),
    .req       (req[1]),
    .halt      (halt[1]),
    .core_reset(cr[1]),
    .core_en   (en[1]),
    .done      (dn[1]),
    .timeout   (to[1]),
    .cycle_cnt (cnt[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int p_init(input int d);
    return (d == 0) ? 2 : 3;
  endfunction

  function automatic int p_drain(input int d);
    return (d == 0) ? 1 : 0;
  endfunction

  function automatic int p_max(input int d);
    return (d == 0) ? 8 : 12;
  endfunction

  // {core_reset, core_en, done, timeout, cycle_cnt}
  function automatic logic [19:0] pk(input logic a, input logic b, input logic c, input logic e,
                                     input logic [15:0] n);
    return {a, b, c, e, n};
  endfunction

  function automatic logic [19:0] obs(input int d);
    return {cr[d], en[d], dn[d], to[d], cnt[d]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [19:0] o, input logic [19:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // One full run: h = RUN cycle (1-based) carrying halt, 0 = never halt.
  task automatic run(input int d, input int h, input int hold);
    int   ini, drn, mx, n, dd, last;
    logic halted;
    logic [19:0] e;
    ini    = p_init(d);
    drn    = p_drain(d);
    mx     = p_max(d);
    halted = (h >= 1 && h <= mx);
    n      = halted ? h : mx;
    dd     = halted ? drn : 0;
    last   = ini + n + dd;
    req[d]  = 1'b1;
    halt[d] = 1'b0;
    for (int j = 0; j <= last; j++) begin
      step();
      if (j < ini)            e = pk(1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
      else if (j < ini + n)   e = pk(1'b0, 1'b1, 1'b0, 1'b0, 16'(j - ini));
      else if (j < last)      e = pk(1'b0, 1'b0, 1'b0, 1'b0, 16'(n));
      else                    e = pk(1'b0, 1'b0, 1'b1, !halted, 16'(n));
      chk($sformatf("run d%0d h%0d j%0d", d, h, j), obs(d), e);
      if (j >= ini && j < ini + n) halt[d] = (j - ini == h - 1);
      else                         halt[d] = 1'($urandom_range(0, 1));
      // req dropping before done is ignored by the sequencer
      req[d] = (j < last) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    for (int m = 0; m < hold; m++) begin
      step();
      chk($sformatf("hold d%0d m%0d", d, m), obs(d), pk(1'b0, 1'b0, 1'b1, !halted, 16'(n)));
      halt[d] = 1'($urandom_range(0, 1));
    end
    req[d] = 1'b0;
    for (int m = 0; m < 2; m++) begin
      step();
      chk($sformatf("idle d%0d m%0d", d, m), obs(d), pk(1'b1, 1'b0, 1'b0, !halted, 16'(n)));
      halt[d] = 1'($urandom_range(0, 1));
    end
    halt[d] = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req[d]  = 1'b0;
      halt[d] = 1'b0;
    end
    #1;
    chk("reset d0", obs(0), pk(1'b1, 1'b0, 1'b0, 1'b0, 16'd0));
    chk("reset d1", obs(1), pk(1'b1, 1'b0, 1'b0, 1'b0, 16'd0));
    step();
    step();
    reset = 1'b0;
    step();

    run(0, 5, 10);
    run(0, 0, 2);
    run(0, 8, 3);
    run(1, 1, 2);
    run(1, 0, 1);

    // asynchronous reset in the middle of RUN, between edges
    req[0] = 1'b1;
    step();
    for (int j = 1; j <= p_init(0) + 3; j++) step();
    chk("pre-reset run", obs(0), pk(1'b0, 1'b1, 1'b0, 1'b0, 16'd3));
    #3;
    reset = 1'b1;
    #1;
    chk("async reset d0", obs(0), pk(1'b1, 1'b0, 1'b0, 1'b0, 16'd0));
    chk("async reset d1", obs(1), pk(1'b1, 1'b0, 1'b0, 1'b0, 16'd0));
    req[0] = 1'b0;
    #2;
    reset = 1'b0;
    step();
    chk("post-reset idle", obs(0), pk(1'b1, 1'b0, 1'b0, 1'b0, 16'd0));

    for (int i = 0; i < 14; i++) begin
      int d, h, hold;
      d    = int'($urandom_range(0, 1));
      h    = int'($urandom_range(0, p_max(d) + 2));
      hold = int'($urandom_range(1, 4));
      run(d, h, hold);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/run_sequencer.md
Name: run_sequencer

Overview:
- Sequences one program run of the single-cycle core.
- Holds the core in reset while idle, releases it on a start request, and counts executed cycles.
- Detects the core's halt, lets the final memory write settle, then reports done through a four-phase req/done handshake.
- A watchdog ends runaway programs with a timeout flag.
- Sits between the bench/host handshake and the core's reset/enable inputs.

Parameters:
- INIT_CYC, 2: cycles core_reset is held after a request is accepted (1..15).
- DRAIN_CYC, 1: cycles between halt and done, with the core frozen (0..15).
- CW, 16: cycle_cnt width.
- MAX_CYC, 16'd50000: watchdog limit in RUN cycles (1..2^CW-1).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; forces IDLE immediately.
- req  in  1  start request from host (level, four-phase).
- halt  in  1  core signals its halt/done instruction is executing (sampled in RUN only).
- core_reset  out  1  synchronous reset to the core's PC/regfile/flags.
- core_en  out  1  core clock-enable; PC and register/memory writes advance only when 1.
- done  out  1  run finished; held until req falls.
- timeout  out  1  last run ended by the watchdog, not by halt.
- cycle_cnt  out  CW  RUN cycles executed in the current/last run.

Behaviour:
- States: IDLE, INIT, RUN, DRAIN, DONE. Moore machine.
  - All outputs are decoded from registered state or driven from registers.
  - There is no combinational path from req or halt to any output.
- Reset (asynchronous, active-high) → IDLE, core_reset=1, core_en=0, done=0, timeout=0, cycle_cnt=0, internal phase counter=0.
- Output decode per state:
  - IDLE: core_reset=1, core_en=0, done=0.
  - INIT: core_reset=1, core_en=0.
  - RUN: core_reset=0, core_en=1.
  - DRAIN: core_reset=0, core_en=0.
  - DONE: core_reset=0, core_en=0, done=1. Core state is preserved for inspection.
- IDLE:
  - req=1 at an edge → INIT.
  - Same edge: cycle_cnt←0, timeout←0, phase counter←0.
- INIT:
  - Phase counter increments each cycle.
  - After exactly INIT_CYC cycles in INIT → RUN, phase counter←0.
- RUN:
  - cycle_cnt increments each cycle, including the cycle in which halt is sampled. It saturates at 2^CW-1.
  - halt=1 → DRAIN, or DONE directly if DRAIN_CYC=0.
  - Otherwise, at the edge where cycle_cnt is MAX_CYC-1 (i.e. after MAX_CYC RUN cycles) → DONE with timeout←1.
  - If halt and the watchdog limit coincide, halt wins: timeout stays 0.
- DRAIN: holds DRAIN_CYC cycles (phase counter), then → DONE. cycle_cnt frozen.
- DONE:
  - done, timeout and cycle_cnt held stable.
  - req=0 → IDLE. core_reset re-asserts in the next cycle; cycle_cnt and timeout keep their values until the next accepted req.
- Handshake rules:
  - A new run starts only after the host drops req in DONE and raises it again in IDLE.
  - req held high through DONE→IDLE does not restart: the IDLE→INIT transition requires req=1 on an edge at least one cycle after entering IDLE. Equivalently, a run starts only on the first IDLE edge where req=1 following an observed req=0.
- req falling in INIT/RUN/DRAIN is ignored; the run completes and done still asserts. The host must see done before dropping req in normal use.
- halt outside RUN is ignored.
- Reset mid-run: immediate IDLE, all outputs to their reset values, no done pulse.
- Latency:
  - req sampled at edge k → first RUN cycle follows edge k+INIT_CYC.
  - halt sampled at edge h → done=1 after edge h+DRAIN_CYC, or after edge h when DRAIN_CYC=0.

Test Plan:
- Defaults (INIT_CYC=2, DRAIN_CYC=1). req rises before edge 1; halt high during the 5th RUN cycle. Required:
  - core_reset=1 through edge 3, core_en=1 for exactly 5 cycles.
  - cycle_cnt=5, done=1 one cycle after halt, timeout=0.
- MAX_CYC=8, halt never asserted → core_en high 8 cycles, then done=1, timeout=1, cycle_cnt=8.
- MAX_CYC=8, halt on 8th RUN cycle → done=1, timeout=0, cycle_cnt=8 (halt wins).
- Handshake: after done, keep req=1 for 10 cycles → done stays 1, cycle_cnt=5 stable.
  - Drop req → IDLE, core_reset=1.
  - Raise req → new run, cycle_cnt clears to 0.
- Reset asserted asynchronously mid-RUN (cycle_cnt=3), between clock edges → core_reset=1, core_en=0, cycle_cnt=0, done=0 immediately, without waiting for an edge.
- DRAIN_CYC=0, halt on 1st RUN cycle → done=1 the next cycle, cycle_cnt=1. halt pulses during IDLE/DONE → no state change.
